// File: rtl/uart_rx_frame_sipo.sv
// UART receive deframer: oversampled start detection, data shift, parity and stop checks,
// feeding a one-entry valid/ready holding register with per-word error flags.
module uart_rx_frame_sipo #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int LSB_FIRST  = 1
) (
    input  logic                  BaudOut,
    input  logic                  ResetN,
    input  logic                  DataTx,
    input  logic                  RxEnable,
    input  logic                  DataReady,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  DataValid,
    output logic                  ParityError,
    output logic                  FrameError,
    output logic                  OverrunError,
    output logic                  Busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rxStateT;

    rxStateT               state, stateNext;
    logic                  syncMeta, syncLine, linePrev;
    logic                  startEdge, tickAtEnd;
    logic [TW-1:0]         tickCnt, tickNext;
    logic [BW-1:0]         bitCnt, bitNext;
    logic [DATA_WIDTH-1:0] shiftReg, shiftNext;
    logic                  parErr, parErrNext;
    logic                  frmErr, frmErrNext;
    logic                  frameDone, frameDoneNext;
    logic                  loadWord;

    // Two-flop synchroniser plus one history flop for the falling-edge start detector.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge BaudOut or negedge ResetN) begin
        if (!ResetN) begin
            syncMeta <= 1'b1;
            syncLine <= 1'b1;
            linePrev <= 1'b1;
        end else begin
            syncMeta <= DataTx;
            syncLine <= syncMeta;
            linePrev <= syncLine;
        end
    end

    assign startEdge = linePrev & ~syncLine;
    assign tickAtEnd = (tickCnt == TICK_LAST);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        stateNext     = state;
        tickNext      = tickCnt;
        bitNext       = bitCnt;
        shiftNext     = shiftReg;
        parErrNext    = parErr;
        frmErrNext    = frmErr;
        frameDoneNext = 1'b0;

        case (state)
            IDLE: begin
                if (startEdge) begin
                    stateNext = START;
                    tickNext  = '0;
                end
            end
            START: begin
                if (tickCnt == TICK_HALF) begin
                    if (syncLine) begin
                        stateNext = IDLE;
                    end else begin
                        stateNext  = DATA;
                        tickNext   = '0;
                        bitNext    = '0;
                        parErrNext = 1'b0;
                        frmErrNext = 1'b0;
                    end
                end else begin
                    tickNext = tickCnt + 1'b1;
                end
            end
            DATA: begin
                if (tickAtEnd) begin
                    tickNext = '0;
                    if (LSB_FIRST != 0) shiftNext = {syncLine, shiftReg[DATA_WIDTH-1:1]};
                    else                shiftNext = {shiftReg[DATA_WIDTH-2:0], syncLine};
                    if (bitCnt == DATA_LAST) begin
                        bitNext   = '0;
                        stateNext = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bitNext = bitCnt + 1'b1;
                    end
                end else begin
                    tickNext = tickCnt + 1'b1;
                end
            end
            PARITY: begin
                if (tickAtEnd) begin
                    tickNext   = '0;
                    parErrNext = ((^shiftReg) ^ syncLine) != PAR_ODD;
                    stateNext  = STOP;
                end else begin
                    tickNext = tickCnt + 1'b1;
                end
            end
            STOP: begin
                if (tickAtEnd) begin
                    tickNext = '0;
                    if (!syncLine) frmErrNext = 1'b1;
                    // Leaving at the last stop-bit centre gives the next start edge a half-bit margin.
                    if (bitCnt == STOP_LAST) begin
                        bitNext       = '0;
                        stateNext     = IDLE;
                        frameDoneNext = 1'b1;
                    end else begin
                        bitNext = bitCnt + 1'b1;
                    end
                end else begin
                    tickNext = tickCnt + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase

        if (!RxEnable) begin
            stateNext     = IDLE;
            tickNext      = '0;
            bitNext       = '0;
            frameDoneNext = 1'b0;
        end
    end

    always_ff @(posedge BaudOut or negedge ResetN) begin
        if (!ResetN) begin
            state     <= IDLE;
            tickCnt   <= '0;
            bitCnt    <= '0;
            shiftReg  <= '0;
            parErr    <= 1'b0;
            frmErr    <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            state     <= stateNext;
            tickCnt   <= tickNext;
            bitCnt    <= bitNext;
            shiftReg  <= shiftNext;
            parErr    <= parErrNext;
            frmErr    <= frmErrNext;
            frameDone <= frameDoneNext;
        end
    end

    // A finished frame loads if the slot is empty or being emptied this edge; otherwise it is dropped.
    assign loadWord = frameDone & (~DataValid | DataReady);

    always_ff @(posedge BaudOut or negedge ResetN) begin
        if (!ResetN) begin
            DataOut      <= '0;
            DataValid    <= 1'b0;
            ParityError  <= 1'b0;
            FrameError   <= 1'b0;
            OverrunError <= 1'b0;
        end else begin
            OverrunError <= frameDone & DataValid & ~DataReady;
            if (loadWord) begin
                DataOut     <= shiftReg;
                ParityError <= parErr;
                FrameError  <= frmErr;
                DataValid   <= 1'b1;
            end else if (DataReady) begin
                DataValid <= 1'b0;
            end
        end
    end

    assign Busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_sipo.sv
// Scoreboard bench for uart_rx_frame_sipo: an 8E1 instance and a 7N2 instance, serial frames
// driven bit by bit, expected words queued at send time and compared on each accepted handshake.
module tb_uart_rx_frame_sipo;
    localparam int OS = 16;

    typedef struct packed {
        logic [8:0] data;
        logic       pe;
        logic       fe;
    } expWordT;

    logic       BaudOut = 1'b0;
    logic       ResetN;
    logic       DataTx, RxEnable, DataReady;
    logic [7:0] DataOut;
    logic       DataValid, ParityError, FrameError, OverrunError, Busy;
    logic       DataTx2, RxEnable2, DataReady2;
    logic [6:0] DataOut2;
    logic       DataValid2, ParityError2, FrameError2, OverrunError2, Busy2;

    expWordT sb1[$];
    expWordT sb2[$];
    int total = 0;
    int bad = 0;
    int validTicks = 0;
    int ovrPulses = 0;
    int words1 = 0;
    int words2 = 0;
    int snapA, snapB;

    always #5 BaudOut = ~BaudOut;

    uart_rx_frame_sipo dut1 (
        .BaudOut(BaudOut), .ResetN(ResetN), .DataTx(DataTx), .RxEnable(RxEnable),
        .DataReady(DataReady), .DataOut(DataOut), .DataValid(DataValid),
        .ParityError(ParityError), .FrameError(FrameError),
        .OverrunError(OverrunError), .Busy(Busy)
    );

    uart_rx_frame_sipo #(.DATA_WIDTH(7), .PARITY_EN(0), .STOP_BITS(2)) dut2 (
        .BaudOut(BaudOut), .ResetN(ResetN), .DataTx(DataTx2), .RxEnable(RxEnable2),
        .DataReady(DataReady2), .DataOut(DataOut2), .DataValid(DataValid2),
        .ParityError(ParityError2), .FrameError(FrameError2),
        .OverrunError(OverrunError2), .Busy(Busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge BaudOut);
    endtask

    task automatic setLine(input int which, input logic v);
        if (which == 0) DataTx = v;
        else            DataTx2 = v;
    endtask

    task automatic push1(input logic [8:0] d, input logic pe, input logic fe);
        sb1.push_back('{data: d, pe: pe, fe: fe});
    endtask

    task automatic push2(input logic [8:0] d, input logic pe, input logic fe);
        sb2.push_back('{data: d, pe: pe, fe: fe});
    endtask

    // Even parity bit computed here, optionally inverted; stopVals[k] is the level of stop bit k.
    task automatic sendFrame(input int which, input logic [8:0] data, input int nbits,
                             input bit parEn, input bit parFlip, input int nstop,
                             input logic [1:0] stopVals);
        logic par;
        par = parFlip;
        setLine(which, 1'b0);
        ticks(OS);
        for (int i = 0; i < nbits; i++) begin
            setLine(which, data[i]);
            par = par ^ data[i];
            ticks(OS);
        end
        if (parEn) begin
            setLine(which, par);
            ticks(OS);
        end
        for (int i = 0; i < nstop; i++) begin
            setLine(which, stopVals[i]);
            ticks(OS);
        end
        setLine(which, 1'b1);
    endtask

    // Monitors sample 2 ns after the falling edge, once the bench has driven that edge's inputs.
    initial begin : mon1
        expWordT e;
        forever begin
            @(negedge BaudOut);
            #2;
            if (DataValid) validTicks++;
            if (OverrunError) ovrPulses++;
            if (DataValid && DataReady) begin
                words1++;
                check("sb1_pending", sb1.size() != 0, 1);
                if (sb1.size() != 0) begin
                    e = sb1.pop_front();
                    check("sb1_data", DataOut, e.data);
                    check("sb1_parity", ParityError, e.pe);
                    check("sb1_frame", FrameError, e.fe);
                end
            end
        end
    end

    initial begin : mon2
        expWordT e;
        forever begin
            @(negedge BaudOut);
            #2;
            if (DataValid2 && DataReady2) begin
                words2++;
                check("sb2_pending", sb2.size() != 0, 1);
                if (sb2.size() != 0) begin
                    e = sb2.pop_front();
                    check("sb2_data", DataOut2, e.data);
                    check("sb2_parity", ParityError2, e.pe);
                    check("sb2_frame", FrameError2, e.fe);
                end
            end
        end
    end

    initial begin
        ResetN = 1'b0;
        DataTx = 1'b1; RxEnable = 1'b1; DataReady = 1'b1;
        DataTx2 = 1'b1; RxEnable2 = 1'b1; DataReady2 = 1'b1;
        ticks(3);
        check("rst_data", DataOut, 8'h00);
        check("rst_valid", DataValid, 0);
        check("rst_perr", ParityError, 0);
        check("rst_ferr", FrameError, 0);
        check("rst_ovr", OverrunError, 0);
        check("rst_busy", Busy, 0);
        check("rst_valid2", DataValid2, 0);
        ResetN = 1'b1;
        ticks(4);

        // Clean 8E1 word, consumer always ready.
        snapA = validTicks;
        push1(9'h0A5, 1'b0, 1'b0);
        sendFrame(0, 9'h0A5, 8, 1'b1, 1'b0, 1, 2'b11);
        ticks(4);
        check("valid_one_tick", validTicks - snapA, 1);

        // Inverted parity bit.
        push1(9'h03C, 1'b1, 1'b0);
        sendFrame(0, 9'h03C, 8, 1'b1, 1'b1, 1, 2'b11);
        ticks(4);

        // Stop bit low.
        push1(9'h096, 1'b0, 1'b1);
        sendFrame(0, 9'h096, 8, 1'b1, 1'b0, 1, 2'b10);
        ticks(2 * OS);

        // Break for three frame times: one all-zero word, then silence until the line rises.
        snapA = words1;
        push1(9'h000, 1'b0, 1'b1);
        DataTx = 1'b0;
        ticks(3 * 11 * OS);
        check("break_busy", Busy, 0);
        DataTx = 1'b1;
        ticks(2 * OS);
        check("break_one_word", words1 - snapA, 1);

        // Four-tick glitch is a false start.
        snapA = validTicks;
        DataTx = 1'b0;
        ticks(4);
        check("glitch_busy_hi", Busy, 1);
        DataTx = 1'b1;
        ticks(2 * OS);
        check("glitch_busy_lo", Busy, 0);
        check("glitch_no_valid", validTicks - snapA, 0);

        // Overrun: second frame dropped while the first waits.
        DataReady = 1'b0;
        snapB = ovrPulses;
        push1(9'h011, 1'b0, 1'b0);
        sendFrame(0, 9'h011, 8, 1'b1, 1'b0, 1, 2'b11);
        sendFrame(0, 9'h022, 8, 1'b1, 1'b0, 1, 2'b11);
        ticks(2);
        check("ovr_pulse", ovrPulses - snapB, 1);
        check("ovr_keep_data", DataOut, 8'h11);
        check("ovr_keep_valid", DataValid, 1);
        DataReady = 1'b1;
        ticks(4);

        // Ready only on the second frame's completion edge: new word replaces the old one.
        DataReady = 1'b0;
        snapB = ovrPulses;
        push1(9'h011, 1'b0, 1'b0);
        sendFrame(0, 9'h011, 8, 1'b1, 1'b0, 1, 2'b11);
        push1(9'h022, 1'b0, 1'b0);
        fork
            sendFrame(0, 9'h022, 8, 1'b1, 1'b0, 1, 2'b11);
            begin
                ticks(16 * 10 + 11);
                DataReady = 1'b1;
                ticks(1);
                DataReady = 1'b0;
            end
        join
        check("swap_valid", DataValid, 1);
        check("swap_data", DataOut, 8'h22);
        check("swap_no_ovr", ovrPulses - snapB, 0);
        DataReady = 1'b1;
        ticks(4);

        // Reset mid-DATA with a word pending in the holding register.
        DataReady = 1'b0;
        sendFrame(0, 9'h077, 8, 1'b1, 1'b0, 1, 2'b11);
        ticks(2);
        check("pre_rst_valid", DataValid, 1);
        fork
            sendFrame(0, 9'h033, 8, 1'b1, 1'b0, 1, 2'b11);
            begin
                ticks(60);
                check("pre_rst_busy", Busy, 1);
                ResetN = 1'b0;
                #1;
                check("midrst_valid", DataValid, 0);
                check("midrst_data", DataOut, 8'h00);
                check("midrst_busy", Busy, 0);
            end
        join
        ResetN = 1'b1;
        DataReady = 1'b1;
        ticks(OS);
        push1(9'h05A, 1'b0, 1'b0);
        sendFrame(0, 9'h05A, 8, 1'b1, 1'b0, 1, 2'b11);
        ticks(4);

        // RxEnable dropped mid-DATA: partial frame discarded.
        snapA = words1;
        fork
            sendFrame(0, 9'h069, 8, 1'b1, 1'b0, 1, 2'b11);
            begin
                ticks(60);
                check("abort_busy_hi", Busy, 1);
                RxEnable = 1'b0;
                ticks(1);
                check("abort_busy_lo", Busy, 0);
            end
        join
        RxEnable = 1'b1;
        ticks(OS);
        check("abort_no_word", words1 - snapA, 0);
        push1(9'h05A, 1'b0, 1'b0);
        sendFrame(0, 9'h05A, 8, 1'b1, 1'b0, 1, 2'b11);
        ticks(4);

        // 7N2 instance: clean word, second stop bit low, then abort and recover.
        push2(9'h05A, 1'b0, 1'b0);
        sendFrame(1, 9'h05A, 7, 1'b0, 1'b0, 2, 2'b11);
        ticks(4);
        push2(9'h02B, 1'b0, 1'b1);
        sendFrame(1, 9'h02B, 7, 1'b0, 1'b0, 2, 2'b01);
        ticks(2 * OS);
        snapA = words2;
        fork
            sendFrame(1, 9'h033, 7, 1'b0, 1'b0, 2, 2'b11);
            begin
                ticks(50);
                check("abort2_busy_hi", Busy2, 1);
                RxEnable2 = 1'b0;
                ticks(1);
                check("abort2_busy_lo", Busy2, 0);
            end
        join
        RxEnable2 = 1'b1;
        ticks(OS);
        check("abort2_no_word", words2 - snapA, 0);
        push2(9'h05A, 1'b0, 1'b0);
        sendFrame(1, 9'h05A, 7, 1'b0, 1'b0, 2, 2'b11);
        ticks(OS);

        check("sb1_drained", sb1.size(), 0);
        check("sb2_drained", sb2.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
